// File: rtl/demux4_fifo.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input stream is steered by sel
// into one of four independent lane FIFOs, each with its own valid/ready output.
module demux4_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic [1:0]                        in_sel,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [4*WIDTH-1:0]                out_data,
  output logic [3:0]                        out_valid,
  input  logic [3:0]                        out_ready,
  output logic [4*$clog2(DEPTH+1)-1:0]      lane_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem   [4][DEPTH];
  logic [PW-1:0]    wptr  [4];
  logic [PW-1:0]    rptr  [4];
  logic [LW-1:0]    level [4];

  logic [3:0] push_en;
  logic [3:0] pop_en;

  // Ready looks only at the addressed lane's occupancy, never at out_ready,
  // so a full lane refuses input even in a cycle where it is being drained.
  always_comb begin
    in_ready = (level[in_sel] != FULL_LEVEL);
    push_en  = 4'b0000;
    pop_en   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      push_en[k] = in_valid && in_ready && (in_sel == 2'(k));
      pop_en[k]  = out_ready[k] && (level[k] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        wptr[k]  <= '0;
        rptr[k]  <= '0;
        level[k] <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem[k][e] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_en[k]) begin
          mem[k][wptr[k]] <= in_data;
          wptr[k]         <= wptr[k] + PW'(1);
        end
        if (pop_en[k]) begin
          rptr[k] <= rptr[k] + PW'(1);
        end
        // Level is kept apart from the pointers so full and empty never alias.
        case ({push_en[k], pop_en[k]})
          2'b10:   level[k] <= level[k] + LW'(1);
          2'b01:   level[k] <= level[k] - LW'(1);
          default: level[k] <= level[k];
        endcase
      end
    end
  end

  always_comb begin
    out_data   = '0;
    out_valid  = 4'b0000;
    lane_level = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k]               = (level[k] != '0);
      out_data[k*WIDTH +: WIDTH] = (level[k] != '0) ? mem[k][rptr[k]] : '0;
      lane_level[k*LW +: LW]     = level[k];
    end
  end

endmodule

// File: tb/tb_demux4_fifo.sv
// Self-checking bench for demux4_fifo: a queue-per-lane reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_demux4_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 reset_n;
  logic [WIDTH-1:0]     in_data;
  logic [1:0]           in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*WIDTH-1:0]   out_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [4*LW-1:0]      lane_level;

  int checks;
  int passed;

  logic [WIDTH-1:0] q [4][$];

  demux4_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lane_level (lane_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each lane is a plain queue; pops see the pre-edge contents,
  // and the push decision uses the pre-edge size of the addressed lane.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      bit do_push;
      do_push = in_valid && (q[in_sel].size() != DEPTH);
      for (int k = 0; k < 4; k++) begin
        if (out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
      end
      if (do_push) q[in_sel].push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [4*WIDTH-1:0] e_data;
    logic [3:0]         e_valid;
    logic [4*LW-1:0]    e_level;
    e_data  = '0;
    e_valid = '0;
    e_level = '0;
    for (int k = 0; k < 4; k++) begin
      e_valid[k]               = (q[k].size() != 0);
      e_data[k*WIDTH +: WIDTH] = (q[k].size() != 0) ? q[k][0] : '0;
      e_level[k*LW +: LW]      = LW'(q[k].size());
    end
    check("model_out_valid",  64'(out_valid),  64'(e_valid));
    check("model_out_data",   64'(out_data),   64'(e_data));
    check("model_lane_level", 64'(lane_level), 64'(e_level));
    check("model_in_ready",   64'(in_ready),   64'(q[in_sel].size() != DEPTH));
  end

  task automatic apply_stimulus(input logic v, input logic [1:0] s,
                                input logic [WIDTH-1:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset_n = 1'b0;
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("reset_out_valid",  64'(out_valid),  64'h0);
    check("reset_lane_level", 64'(lane_level), 64'h0);
    check("reset_out_data",   64'(out_data),   64'h0);
    check("reset_in_ready",   64'(in_ready),   64'h1);

    // single route to lane 1
    tick();
    apply_stimulus(1'b1, 2'd1, 8'hA5, 4'b0000);
    tick();
    check("route_out_valid",  64'(out_valid),  64'h2);
    check("route_out_data",   64'(out_data),   64'h0000A500);
    check("route_lane_level", 64'(lane_level), 64'h04);
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'b0010);
    tick();
    check("route_drained", 64'(out_valid), 64'h0);

    // fill lane 3 and backpressure
    apply_stimulus(1'b1, 2'd3, 8'h11, 4'b0000);
    tick();
    apply_stimulus(1'b1, 2'd3, 8'h22, 4'b0000);
    tick();
    check("fill_level3", 64'(lane_level), 64'h80);
    apply_stimulus(1'b1, 2'd3, 8'h33, 4'b0000);
    #1 check("full_ready_sel3", 64'(in_ready), 64'h0);
    in_sel = 2'd0;
    #1 check("full_ready_sel0", 64'(in_ready), 64'h1);
    in_sel = 2'd3;
    tick();
    check("extra_push_refused", 64'(lane_level), 64'h80);
    check("head_11", 64'(out_data[31:24]), 64'h11);
    apply_stimulus(1'b0, 2'd3, 8'h00, 4'b1000);
    tick();
    check("head_22",         64'(out_data[31:24]), 64'h22);
    check("ready_sel3_back", 64'(in_ready),        64'h1);
    tick();
    check("lane3_empty", 64'(lane_level), 64'h00);

    // concurrent push/pop with pointer wrap
    apply_stimulus(1'b1, 2'd0, 8'h01, 4'b0000);
    tick();
    check("conc_head_01", 64'(out_data[7:0]), 64'h01);
    for (int i = 0; i <= DEPTH; i++) begin
      apply_stimulus(1'b1, 2'd0, 8'(8'h02 + i), 4'b0001);
      tick();
      check("conc_level0", 64'(lane_level[LW-1:0]), 64'h1);
      check("conc_head",   64'(out_data[7:0]),      64'(8'h02 + i));
    end
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();

    // lane independence with lane 2 full and stalled
    apply_stimulus(1'b1, 2'd2, 8'hA0, 4'b0000);
    tick();
    apply_stimulus(1'b1, 2'd2, 8'hA1, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd1 : 2'd3;
      apply_stimulus(1'b1, s, 8'(8'h10 + i), 4'b1011);
      tick();
      check("indep_word",  64'(out_data[s*WIDTH +: WIDTH]), 64'(8'h10 + i));
      check("indep_lane2", 64'(out_data[23:16]),            64'hA0);
    end
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'b1011);
    tick();
    check("indep_level", 64'(lane_level), 64'h20);

    // reset mid-stream discards lane 2 contents
    apply_stimulus(1'b1, 2'd2, 8'hEE, 4'b0000);
    #2 reset_n = 1'b0;
    #1 check("midreset_valid", 64'(out_valid), 64'h0);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_out_valid",  64'(out_valid),  64'h0);
    check("rel_lane_level", 64'(lane_level), 64'h0);
    check("rel_out_data",   64'(out_data),   64'h0);
    check("rel_in_ready",   64'(in_ready),   64'h1);

    // popping empty lanes
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'b1111);
    repeat (5) begin
      tick();
      check("empty_level", 64'(lane_level), 64'h0);
      check("empty_known", 64'($isunknown({out_data, out_valid, lane_level, in_ready})), 64'h0);
    end

    tick();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
